// File: rtl/sync_debouncer_pkg.sv
// Shared types and constants for the input conditioning path.
// Used by the debouncer and reused by the edge detector benches.
package edge_pkg;

   typedef enum logic {
      STABLE = 1'b0,
      CHECK  = 1'b1
   } state_e;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;

   // Width of the qualification counter; never below one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/sync_debouncer_if.sv
// Signal bundle between a raw-input source and the debouncer.
// The slave side is the debouncer; the master drives the raw input.
interface sync_debouncer_if #(
   parameter int GLITCH_W = 8
);

   logic                a_raw;
   logic                glitch_clr;
   logic                a_clean;
   logic                busy;
   logic [GLITCH_W-1:0] glitch_cnt;

   modport master (
      output a_raw,
      output glitch_clr,
      input  a_clean,
      input  busy,
      input  glitch_cnt
   );

   modport slave (
      input  a_raw,
      input  glitch_clr,
      output a_clean,
      output busy,
      output glitch_cnt
   );

endinterface

// File: rtl/sync_debouncer_sync_chain.sv
// N-flop synchronizer for an asynchronous single-bit input.
// Output is the last flop of the chain; reset clears every stage.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] s_q;

   // Shift the raw sample one stage deeper on every edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q <= '0;
      end else begin
         s_q <= {s_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = s_q[STAGES-1];

endmodule

// File: rtl/sync_debouncer.sv
// Synchronizes and debounces a raw input into a clean level.
// Rejected level changes are tallied in a saturating counter.
module sync_debouncer
   import edge_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int GLITCH_W        = 8
) (
   input  logic           clk,
   input  logic           reset,
   sync_debouncer_if.slave bus
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);

   localparam logic [0:0] S_STABLE = 1'(STABLE);
   localparam logic [0:0] S_CHECK  = 1'(CHECK);

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [GLITCH_W-1:0] GL_MAX = '1;
   localparam logic [GLITCH_W-1:0] GL_ONE = GLITCH_W'(1);

   logic                a_sync;
   logic [0:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                clean_q, clean_d;
   logic [GLITCH_W-1:0] gl_q, gl_d;
   logic                reject;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (bus.a_raw),
      .q_o   (a_sync)
   );

   // Qualify a candidate level for DEBOUNCE_CYCLES consecutive edges.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      reject  = 1'b0;
      case (state_q)
         S_STABLE: begin
            cnt_d = '0;
            if (a_sync != clean_q) begin
               state_d = S_CHECK;
               cnt_d   = CNT_ONE;
            end
         end
         S_CHECK: begin
            if (a_sync == clean_q) begin
               reject  = 1'b1;
               cnt_d   = '0;
               state_d = S_STABLE;
            end else if (cnt_q == CNT_LAST) begin
               clean_d = a_sync;
               cnt_d   = '0;
               state_d = S_STABLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Clear wins over a simultaneous rejection; count saturates.
   always_comb begin
      gl_d = gl_q;
      if (bus.glitch_clr) begin
         gl_d = '0;
      end else if (reject && (gl_q != GL_MAX)) begin
         gl_d = gl_q + GL_ONE;
      end
   end

   // State, counter, clean level and glitch tally registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_STABLE;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         gl_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         gl_q    <= gl_d;
      end
   end

   assign bus.a_clean    = clean_q;
   assign bus.busy       = (state_q == S_CHECK);
   assign bus.glitch_cnt = gl_q;

endmodule

// File: tb/tb_sync_debouncer.sv
// Randomized and directed bench for sync_debouncer.
// A run-length reference model predicts every output each cycle.
module tb_sync_debouncer;

   localparam int SS = 2;
   localparam int DC = 4;
   localparam int GW = 8;
   localparam int GMAX = (1 << GW) - 1;

   logic clk = 1'b0;
   logic reset = 1'b0;

   sync_debouncer_if #(.GLITCH_W(GW)) bus ();

   sync_debouncer #(
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DC),
      .GLITCH_W        (GW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   bit m_q[$];
   bit m_clean;
   int m_run;
   int m_gl;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      repeat (SS) m_q.push_back(1'b0);
      m_clean = 1'b0;
      m_run   = 0;
      m_gl    = 0;
   endtask

   // Model: the level seen SS edges ago must differ for DC edges.
   task automatic m_step();
      bit s;
      bit rej;
      if (!reset) begin
         m_reset();
         return;
      end
      s   = m_q.pop_front();
      m_q.push_back(bus.a_raw);
      rej = 1'b0;
      if (s != m_clean) begin
         m_run++;
         if (m_run == DC) begin
            m_clean = s;
            m_run   = 0;
         end
      end else begin
         if (m_run > 0) rej = 1'b1;
         m_run = 0;
      end
      if (bus.glitch_clr) m_gl = 0;
      else if (rej && m_gl < GMAX) m_gl++;
   endtask

   task automatic cmp();
      chk("a_clean", 32'(bus.a_clean), 32'(m_clean));
      chk("busy", 32'(bus.busy), 32'(m_run > 0));
      chk("glitch_cnt", 32'(bus.glitch_cnt), 32'(m_gl));
   endtask

   task automatic tick(input bit raw, input bit clr);
      bus.a_raw      = raw;
      bus.glitch_clr = clr;
      @(posedge clk);
      m_step();
      @(negedge clk);
      cmp();
   endtask

   task automatic async_reset(input bit raw);
      #2 reset = 1'b0;
      #1;
      m_reset();
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_clean", 32'(bus.a_clean), 32'd0);
      chk("arst_gl", 32'(bus.glitch_cnt), 32'd0);
      tick(raw, 1'b0);
      reset = 1'b1;
   endtask

   initial begin
      bit raw;
      int len;
      bus.a_raw      = 1'b1;
      bus.glitch_clr = 1'b0;
      m_reset();

      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0);
         chk("rst_clean", 32'(bus.a_clean), 32'd0);
         chk("rst_busy", 32'(bus.busy), 32'd0);
      end
      reset = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick(1'b1, 1'b0);
         if (e == 2) chk("rel_busy2", 32'(bus.busy), 32'd0);
         if (e == 3) chk("rel_busy3", 32'(bus.busy), 32'd1);
         if (e == 5) chk("rel_clean5", 32'(bus.a_clean), 32'd0);
         if (e == 6) chk("rel_clean6", 32'(bus.a_clean), 32'd1);
      end

      repeat (10) tick(1'b0, 1'b0);
      for (int e = 1; e <= 10; e++) begin
         tick(1'b1, 1'b0);
         if (e >= 3 && e <= 5) chk("rise_busy", 32'(bus.busy), 32'd1);
         if (e >= 6) chk("rise_clean", 32'(bus.a_clean), 32'd1);
      end
      chk("rise_gl", 32'(bus.glitch_cnt), 32'd0);

      repeat (10) tick(1'b0, 1'b0);
      for (int g = 0; g < 260; g++) begin
         repeat (3) tick(1'b1, 1'b0);
         repeat (7) tick(1'b0, 1'b0);
         if (g == 0) chk("glitch_one", 32'(bus.glitch_cnt), 32'd1);
         chk("glitch_clean", 32'(bus.a_clean), 32'd0);
      end
      chk("glitch_sat", 32'(bus.glitch_cnt), 32'(GMAX));

      repeat (3) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      chk("clr_collide", 32'(bus.glitch_cnt), 32'd0);
      repeat (5) tick(1'b0, 1'b0);
      repeat (3) tick(1'b1, 1'b0);
      repeat (7) tick(1'b0, 1'b0);
      chk("clr_next", 32'(bus.glitch_cnt), 32'd1);

      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      for (int e = 1; e <= 10; e++) begin
         tick(1'b1, 1'b0);
         if (e == 5) chk("bounce_c5", 32'(bus.a_clean), 32'd0);
         if (e == 6) chk("bounce_c6", 32'(bus.a_clean), 32'd1);
      end
      chk("bounce_gl", 32'(bus.glitch_cnt), 32'd3);

      repeat (10) tick(1'b0, 1'b0);
      repeat (4) tick(1'b1, 1'b0);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      async_reset(1'b1);
      for (int e = 1; e <= 8; e++) begin
         tick(1'b1, 1'b0);
         if (e == 5) chk("mid_c5", 32'(bus.a_clean), 32'd0);
         if (e == 6) chk("mid_c6", 32'(bus.a_clean), 32'd1);
      end

      for (int k = 0; k < 400; k++) begin
         raw = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 8);
         for (int j = 0; j < len; j++) begin
            tick(raw, $urandom_range(0, 15) == 0);
         end
         if ($urandom_range(0, 40) == 0) async_reset(raw);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got running expected done");
      $fatal(1);
   end

endmodule
